// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin grant sequencer: requester count,
// index width, FSM state encoding and the pointer-increment helper.
package rr_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Advance a requester pointer by one, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] ptr);
    return ptr + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: scans req upward starting one past last_ptr and
// returns the first set bit. The last-served requester is checked last.
module rr_pick
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  assign start = next_ptr(last_ptr);

  // Scan offsets from the far end down so the nearest candidate wins last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (req[cand]) begin
        pick = cand;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Four-requester round-robin arbiter with hold-until-release handshaking,
// a per-grant hold timeout and a one-cycle dead gap between grants.
// All outputs are registered; grant_idx feeds a downstream 2-to-4 decoder
// and must be qualified by grant_valid.
module rr_grant_sequencer
  import rr_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] last_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             release_now;

  rr_pick u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .any      (any)
  );

  // A grant ends when the grantee strobes done or drops its own request.
  assign release_now = done | ~req[grant_idx];

  // Arbitration FSM: IDLE/GAP pick a new grantee, GRANT holds until release or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last_ptr    <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE, GAP: begin
          timeout <= 1'b0;
          if (any) begin
            state       <= GRANT;
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            last_ptr    <= pick;
            hold_cnt    <= '0;
          end else begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Release takes precedence over an expiring hold: no timeout pulse.
            state       <= GAP;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= GAP;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: a behavioural reference pushes the expected
// outputs for each driven cycle into a queue, which is popped and compared
// after the clock edge; directed scenarios add explicit expectations.
module tb_rr_grant_sequencer;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_grant_sequencer #(.MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  typedef struct {
    int idx;
    int vld;
    int to;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: 0=idle, 1=grant, 2=gap
  int m_state = 0;
  int m_idx   = 0;
  int m_vld   = 0;
  int m_to    = 0;
  int m_hold  = 0;
  int m_last  = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mpick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r, input logic d);
    int p;
    if (r_rst) begin
      m_state = 0; m_idx = 0; m_vld = 0; m_to = 0; m_hold = 0; m_last = 3;
    end else if (m_state == 1) begin
      if (d || !r[m_idx]) begin
        m_state = 2; m_vld = 0; m_to = 0;
      end else if (m_hold == MAXH - 1) begin
        m_state = 2; m_vld = 0; m_to = 1;
      end else begin
        m_hold = m_hold + 1;
      end
    end else begin
      m_to = 0;
      p = mpick(r, m_last);
      if (p >= 0) begin
        m_state = 1; m_idx = p; m_vld = 1; m_last = p; m_hold = 0;
      end else begin
        m_state = 0; m_vld = 0;
      end
    end
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    rst  = r_rst;
    req  = r;
    done = d;
    model_step(r_rst, r, d);
    e.idx = m_idx;
    e.vld = m_vld;
    e.to  = m_to;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("sb_idx", 32'(grant_idx), 32'(e.idx));
      chk("sb_vld", 32'(grant_valid), 32'(e.vld));
      chk("sb_to", 32'(timeout), 32'(e.to));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
  endtask

  initial begin
    int order[5];
    int nvld;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    order = '{0, 1, 2, 3, 0};

    // Reset state
    do_reset();
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_vld", 32'(grant_valid), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);

    // Single requester, done pulse, then back to idle
    step(1'b0, 4'b0001, 1'b0);
    chk("single_idx", 32'(grant_idx), 32'd0);
    chk("single_vld", 32'(grant_valid), 32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("single_gap", 32'(grant_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b0);
    chk("single_idle", 32'(grant_valid), 32'd0);

    // All requesting, done every grant: rotation order with gaps
    do_reset();
    step(1'b0, 4'b1111, 1'b0);
    chk("rr_0", 32'(grant_idx), 32'(order[0]));
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("rr_gap", 32'(grant_valid), 32'd0);
      step(1'b0, 4'b1111, 1'b0);
      chk("rr_idx", 32'(grant_idx), 32'(order[i]));
      chk("rr_vld", 32'(grant_valid), 32'd1);
    end

    // Hold timeout with req held, then re-grant of the same requester
    do_reset();
    step(1'b0, 4'b0100, 1'b0);
    nvld = (grant_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0100, 1'b0);
      if (grant_valid !== 1'b1) break;
      nvld++;
    end
    chk("hold_len", 32'(nvld), 32'(MAXH));
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_gap_vld", 32'(grant_valid), 32'd0);
    step(1'b0, 4'b0100, 1'b0);
    chk("to_clear", 32'(timeout), 32'd0);
    chk("regrant_idx", 32'(grant_idx), 32'd2);
    chk("regrant_vld", 32'(grant_valid), 32'd1);

    // Grantee drops its request without done
    do_reset();
    step(1'b0, 4'b0010, 1'b0);
    chk("drop_idx", 32'(grant_idx), 32'd1);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("drop_vld", 32'(grant_valid), 32'd0);
    chk("drop_to", 32'(timeout), 32'd0);

    // done coincides with the last hold cycle: release wins
    do_reset();
    step(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < MAXH - 1; i++) step(1'b0, 4'b0001, 1'b0);
    chk("edge_still_vld", 32'(grant_valid), 32'd1);
    step(1'b0, 4'b0001, 1'b1);
    chk("edge_vld", 32'(grant_valid), 32'd0);
    chk("edge_to", 32'(timeout), 32'd0);

    // Reset mid-grant
    do_reset();
    step(1'b0, 4'b1000, 1'b0);
    chk("mid_idx", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("midrst_idx", 32'(grant_idx), 32'd0);
    chk("midrst_vld", 32'(grant_valid), 32'd0);
    chk("midrst_to", 32'(timeout), 32'd0);
    step(1'b0, 4'b1000, 1'b0);
    chk("postrst_idx", 32'(grant_idx), 32'd3);
    chk("postrst_vld", 32'(grant_valid), 32'd1);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
- Four-requester round-robin arbiter that produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 decoder. The index drives the decoder's 2-bit select input, and the decoder's one-hot output becomes the grant lines, gated by grant_valid.
- Adds hold-until-release handshaking, a per-grant timeout and a one-cycle dead gap between grants.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 to match the 2-bit decoder select.
- IDX_W, 2, width of the grant index.
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] is high while requester i wants the resource.
- done  input  1  release strobe from the current grantee; sampled only in GRANT.
- grant_idx  output  2  index of the granted requester; feeds the decoder select.
- grant_valid  output  1  high while grant_idx names a live grant.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset: synchronous. At a clk edge with rst=1:
  - state=IDLE, grant_idx=2'b00, grant_valid=0, timeout=0, hold_cnt=0.
  - last_ptr=2'b11, so req[0] has the highest priority after reset.
  - A reset asserted mid-grant drops grant_valid at that same edge. No timeout pulse is generated.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States are IDLE, GRANT and GAP.
- IDLE:
  - If req != 0, pick the first set bit scanning upward from (last_ptr+1) mod 4, wrapping 3 to 0.
  - At that edge: grant_idx=pick, grant_valid=1, last_ptr=pick, hold_cnt=0, go to GRANT.
  - If req == 0, stay in IDLE; outputs unchanged except grant_valid=0.
- GRANT (grant_valid=1, grant_idx stable for the whole state):
  - Release condition: done=1, or req[grant_idx]=0 (requester dropped its request).
    - On release: go to GAP, grant_valid=0, timeout=0.
  - Else if hold_cnt == MAX_HOLD-1: go to GAP, grant_valid=0, timeout=1 for exactly the GAP cycle.
  - Else: hold_cnt increments by 1.
  - Simultaneous release and hold_cnt == MAX_HOLD-1: the release wins and no timeout pulse is produced.
  - Changes on other req bits are ignored during GRANT.
- GAP (exactly one cycle, grant_valid=0):
  - timeout returns to 0 at the exit edge.
  - Arbitration uses the same rule as IDLE. If req != 0, go straight to GRANT with the new pick; otherwise go to IDLE.
  - The requester just served is the lowest priority. A requester that still holds req therefore waits behind all others.
- grant_idx keeps its last value whenever grant_valid=0. Downstream logic must gate on grant_valid.
- Latency:
  - Request to grant: 1 edge.
  - Release to next grant: 2 edges (the GRANT to GAP edge, then the GAP to GRANT edge).
- Starvation bound: any continuously asserted request is granted within 3 × (MAX_HOLD+1) + 1 cycles.
- hold_cnt width is clog2(MAX_HOLD). The counter never wraps because the timeout fires first.

Decomposition:
- Shared package rr_pkg holds:
  - N_REQ, IDX_W.
  - State enum state_t {IDLE, GRANT, GAP}.
  - Function next_ptr(ptr) implementing the mod-4 increment.
- One sub-module, rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[3:0], last_ptr[1:0].
  - Outputs: pick[1:0], any.
  - Instantiated once; used by both the IDLE and GAP arbitration.
- The 2-to-4 decoder stays a separate instance downstream in the enclosing level and is not part of this block.

Test Plan:
- Reset then req=4'b0001 -> one edge later grant_idx=00, grant_valid=1; done pulse -> grant_valid=0 for one cycle, then IDLE once req is cleared.
- req=4'b1111 held, done pulsed every grant -> grant order 00,01,10,11,00, with one grant_valid=0 cycle between each grant.
- req=4'b0100 held, done never asserted, MAX_HOLD=8 -> grant_valid high for exactly 8 cycles, then timeout=1 for 1 cycle with grant_valid=0; if req still held, re-grant 10 on the next edge.
- Granted requester drops req[1] mid-grant with done=0 -> next edge grant_valid=0 and timeout=0.
- done asserted on the same cycle hold_cnt reaches 7 -> GAP entered, timeout stays 0.
- rst asserted during GRANT with grant_idx=11 -> next edge grant_idx=00, grant_valid=0, timeout=0; with req=4'b1000 still held, re-grant 11 one edge after rst deasserts.
